dmem_access_unit: RTL
=====================

Name: dmem_access_unit

Overview:
- MEM-stage data-memory port; consumes the access fields held in the EX/MEM pipeline register and performs one data-bus transaction per load/store.
- Fields consumed: enable, write, type, sign-extend, address (ALU result), store data (rt).
- Generates byte enables and lane-replicated store data, sign/zero-extends load data, and stalls the pipeline until the bus completes.
- Its stall output drives the EX/MEM hold input.

Parameters:
- BIG_ENDIAN, 0, byte-lane order. 0 means byte at addr[1:0]=0 is on bits 7:0; 1 means it is on bits 31:24.
- TIMEOUT_CYCLES, 255, BUSY cycles without ack before a bus error is declared (1..255).

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-low reset
- mem_dmen  in  1  access valid (from EX/MEM)
- mem_memwr  in  1  1=store, 0=load
- mem_dm_type  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
- mem_dm_extsigned  in  1  load sign-extend enable
- mem_result  in  32  byte address
- mem_rt  in  32  store data, right-justified
- dbus_req  out  1  bus request
- dbus_we  out  1  bus write
- dbus_addr  out  32  word address, bits 1:0 forced to 0
- dbus_be  out  4  byte enables
- dbus_wdata  out  32  lane-replicated store data
- dbus_rdata  in  32  read data, valid with ack
- dbus_ack  in  1  transaction complete
- mem_load_data  out  32  extended load result
- mem_stall  out  1  hold EX/MEM and earlier stages
- mem_misalign  out  1  one-cycle misaligned-access pulse
- mem_buserr  out  1  one-cycle bus-timeout pulse

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE; timeout counter goes to 0.
  - All registered outputs go to 0: dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata, mem_load_data, mem_buserr.
  - mem_stall is 0 and mem_misalign is 0.
  - Reset mid-transaction abandons it immediately; the bus must tolerate the request dropping.
- Misalignment check (combinational on inputs):
  - half with addr[0]=1 is misaligned.
  - word or reserved type with addr[1:0]!=0 is misaligned.
- State IDLE:
  - If mem_dmen=1 and not misaligned: mem_stall=1 (combinational).
  - On that edge: latch dbus_we, dbus_addr, dbus_be, dbus_wdata, type, extsigned and addr[1:0]; set dbus_req=1; go to BUSY.
  - If mem_dmen=1 and misaligned: mem_misalign=1 combinationally, no stall, no request, mem_load_data=0, stay in IDLE.
  - If mem_dmen=0: stay in IDLE, mem_stall=0.
- State BUSY:
  - mem_stall=1 and dbus_req=1; request fields stay stable.
  - On dbus_ack=1: capture the formatted dbus_rdata into mem_load_data (loads only; stores write 0), drop dbus_req, go to DONE.
  - Otherwise increment the counter. If counter==TIMEOUT_CYCLES-1 without ack: drop req, mem_load_data=0, pulse mem_buserr in the DONE cycle, go to DONE.
- State DONE:
  - mem_stall=0; the pipeline advances on this edge.
  - mem_load_data holds through this cycle.
  - Go to IDLE, clear counter and mem_buserr.
  - A new access seen in IDLE on the next cycle is a new instruction; no re-issue is possible.
- Latency: zero-wait ack gives 2 stall cycles plus 1 DONE cycle, so 3 cycles per access. Each extra wait cycle adds 1.
- Byte enables (little-endian, BIG_ENDIAN=0):
  - byte: 0001 << addr[1:0]
  - half: 0011 << addr[1:0]
  - word: 1111
  - BIG_ENDIAN=1 mirrors lane indices (lane = 3 - index).
- Store data:
  - byte: rt[7:0] replicated x4
  - half: rt[15:0] replicated x2
  - word: rt
- Load formatting:
  - Select the lane(s) by latched addr[1:0] and endianness.
  - byte/half are sign-extended if extsigned=1, else zero-extended.
  - word passes through.
- dbus_ack outside BUSY is ignored.

Decomposition:
- Shared core package holds:
  - DM_BYTE/DM_HALF/DM_WORD type encodings;
  - state encoding IDLE/BUSY/DONE;
  - lane-select helper constants.
- One natural sub-module: dmem_lane_format, combinational. It produces be/wdata from type, addr and rt, and load data from rdata, type, addr and extsigned. It is reused by a future instruction-fetch/uncached port.

Test Plan:
- Word store: addr=0x100, rt=0xDEADBEEF, ack after 2 waits -> dbus_be=1111, wdata=0xDEADBEEF, addr=0x100, mem_stall high 4 cycles, then one DONE cycle with stall=0.
- Byte load, signed: addr=0x203, rdata=0x80112233 with zero-wait ack -> mem_load_data=0xFFFFFF80. Same access with extsigned=0 -> 0x00000080. Both with BIG_ENDIAN=0.
- Half store: addr=0x302, rt=0x0000ABCD -> be=1100, wdata=0xABCDABCD. With BIG_ENDIAN=1 -> be=0011.
- Misaligned word load at addr=0x105 -> mem_misalign pulses 1 cycle, dbus_req never asserts, mem_stall=0.
- Timeout: no ack, TIMEOUT_CYCLES=4 -> req held exactly 4 BUSY cycles, mem_buserr pulse, mem_load_data=0, return to IDLE.
- Reset asserted in BUSY -> dbus_req and mem_stall drop without waiting for a clock. After release the FSM is in IDLE and the next access proceeds normally.

Source files
------------

// File: rtl/dmem_access_unit_pkg.sv
// Shared definitions for the MEM-stage data-memory port.
// Type encodings, FSM states and byte-lane helpers.
package dmem_access_unit_pkg;

  localparam logic [1:0] DM_BYTE = 2'b00;
  localparam logic [1:0] DM_HALF = 2'b01;
  localparam logic [1:0] DM_WORD = 2'b10;
  localparam logic [1:0] DM_RSVD = 2'b11;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } dm_state_t;

  // Physical lane for a byte index within the word.
  function automatic logic [1:0] lane_of(
    input logic [1:0] idx,
    input logic       big
  );
    return big ? ~idx : idx;
  endfunction

endpackage

// File: rtl/dmem_lane_format.sv
// Byte-lane steering for stores and
// lane selection plus extension for loads.
module dmem_lane_format
  import dmem_access_unit_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic [1:0]  dm_type,
  input  logic [1:0]  addr_lo,
  input  logic        extsigned,
  input  logic [31:0] rt,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [1:0]  byte_lane;
  logic        half_hi;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  // Steer store lanes and format load data by access size.
  always_comb begin
    be        = BE_WORD;
    wdata     = rt;
    load_data = rdata;
    byte_lane = lane_of(addr_lo, BIG_ENDIAN);
    half_hi   = addr_lo[1] ^ BIG_ENDIAN;
    rd_byte   = rdata[{byte_lane, 3'b000} +: 8];
    rd_half   = half_hi ? rdata[31:16] : rdata[15:0];
    unique case (1'b1)
      dm_type == DM_BYTE: begin
        be        = BE_BYTE << byte_lane;
        wdata     = {4{rt[7:0]}};
        load_data = {{24{extsigned & rd_byte[7]}},
                     rd_byte};
      end
      dm_type == DM_HALF: begin
        be        = BE_HALF << {half_hi, 1'b0};
        wdata     = {2{rt[15:0]}};
        load_data = {{16{extsigned & rd_half[15]}},
                     rd_half};
      end
      default: begin
        be        = BE_WORD;
        wdata     = rt;
        load_data = rdata;
      end
    endcase
  end

endmodule

// File: rtl/dmem_access_unit.sv
// MEM-stage data-memory port: one bus transaction
// per load/store, stalling EX/MEM until it completes.
module dmem_access_unit
  import dmem_access_unit_pkg::*;
#(
  parameter bit BIG_ENDIAN     = 1'b0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_dmen,
  input  logic        mem_memwr,
  input  logic [1:0]  mem_dm_type,
  input  logic        mem_dm_extsigned,
  input  logic [31:0] mem_result,
  input  logic [31:0] mem_rt,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_wdata,
  input  logic [31:0] dbus_rdata,
  input  logic        dbus_ack,
  output logic [31:0] mem_load_data,
  output logic        mem_stall,
  output logic        mem_misalign,
  output logic        mem_buserr
);

  localparam logic [7:0] TO_LAST =
    8'(TIMEOUT_CYCLES - 1);

  dm_state_t   state_q, state_d;
  logic [1:0]  type_q;
  logic [1:0]  addr_lo_q;
  logic        ext_q;
  logic [7:0]  cnt_q;
  logic        misaligned;
  logic        start;
  logic        timeout;
  logic        fmt_idle;
  logic [1:0]  fmt_type;
  logic [1:0]  fmt_addr;
  logic [3:0]  fmt_be;
  logic [31:0] fmt_wdata;
  logic [31:0] fmt_load;

  // Alignment check on the incoming access.
  always_comb begin
    misaligned = 1'b0;
    unique case (1'b1)
      mem_dm_type == DM_BYTE: misaligned = 1'b0;
      mem_dm_type == DM_HALF: misaligned = mem_result[0];
      default: misaligned = |mem_result[1:0];
    endcase
  end

  assign start   = (state_q == IDLE) && mem_dmen
                   && !misaligned;
  assign timeout = cnt_q == TO_LAST;

  // Formatter sees live fields in IDLE, latched ones after.
  assign fmt_idle = state_q == IDLE;
  assign fmt_type = fmt_idle ? mem_dm_type : type_q;
  assign fmt_addr = fmt_idle ? mem_result[1:0]
                             : addr_lo_q;

  dmem_lane_format #(
    .BIG_ENDIAN(BIG_ENDIAN)
  ) u_fmt (
    .dm_type  (fmt_type),
    .addr_lo  (fmt_addr),
    .extsigned(ext_q),
    .rt       (mem_rt),
    .rdata    (dbus_rdata),
    .be       (fmt_be),
    .wdata    (fmt_wdata),
    .load_data(fmt_load)
  );

  // Next state, stall and misalign strobes.
  // Both strobes are gated by reset so they drop at once.
  always_comb begin
    state_d      = state_q;
    mem_stall    = 1'b0;
    mem_misalign = 1'b0;
    unique case (state_q)
      IDLE: if (start) state_d = BUSY;
      BUSY: if (dbus_ack || timeout) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    mem_stall = reset &&
                (start || state_q == BUSY);
    mem_misalign = reset && fmt_idle &&
                   mem_dmen && misaligned;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Bus request fields, timeout counter and results.
  // Load data is cleared leaving DONE so IDLE reads 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dbus_req      <= 1'b0;
      dbus_we       <= 1'b0;
      dbus_addr     <= '0;
      dbus_be       <= '0;
      dbus_wdata    <= '0;
      mem_load_data <= '0;
      mem_buserr    <= 1'b0;
      type_q        <= DM_BYTE;
      addr_lo_q     <= '0;
      ext_q         <= 1'b0;
      cnt_q         <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            dbus_req   <= 1'b1;
            dbus_we    <= mem_memwr;
            dbus_addr  <= {mem_result[31:2], 2'b00};
            dbus_be    <= fmt_be;
            dbus_wdata <= fmt_wdata;
            type_q     <= mem_dm_type;
            addr_lo_q  <= mem_result[1:0];
            ext_q      <= mem_dm_extsigned;
            cnt_q      <= '0;
          end else if (mem_dmen) begin
            mem_load_data <= '0;
          end
        end
        BUSY: begin
          if (dbus_ack) begin
            dbus_req      <= 1'b0;
            mem_load_data <= dbus_we ? '0 : fmt_load;
          end else if (timeout) begin
            dbus_req      <= 1'b0;
            mem_load_data <= '0;
            mem_buserr    <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        DONE: begin
          cnt_q         <= '0;
          mem_buserr    <= 1'b0;
          mem_load_data <= '0;
        end
        default: begin
          dbus_req <= 1'b0;
          cnt_q    <= '0;
        end
      endcase
    end
  end

endmodule
